fetch_queue: RTL and testbench

Instruction fetch queue between the frontend stage and the decode stage. It accepts fetched {pc, instruction, misaligned flag} triples from the frontend and buffers them in a small in-order FIFO. It presents them to decode with a valid/ready handshake, which decouples L1.5 fetch latency from decode stalls. A flush input, driven by redirects, kills, and exception entry, discards all buffered words in one cycle.

---
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between frontend and decode, with single-cycle flush.
// Optional zero-latency empty-queue bypass is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       enq_valid,
    input  logic [31:0]                enq_pc,
    input  logic [31:0]                enq_instr,
    input  logic                       enq_misaligned,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_instr,
    output logic                       deq_misaligned,
    input  logic                       deq_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Entry layout: {misaligned, pc, instr}
    logic [64:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full, empty;
    logic          wr_en, rd_fire;
    logic [64:0]   head;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq_ready = !full;
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign rd_fire   = !empty && deq_ready && !flush;

`ifdef FETCHQ_BYPASS_EN
    logic bypass;
    assign bypass = empty && enq_valid && !flush;
    // A bypassed word taken by decode in the same cycle never touches storage.
    assign wr_en  = enq_valid && !full && !flush && !(bypass && deq_ready);
`else
    assign wr_en  = enq_valid && !full && !flush;
`endif

    always_comb begin
        deq_valid      = 1'b0;
        deq_pc         = 32'h0;
        deq_instr      = NOP_INSTR;
        deq_misaligned = 1'b0;
        if (!empty) begin
            deq_valid      = 1'b1;
            deq_misaligned = head[64];
            deq_pc         = head[63:32];
            deq_instr      = head[31:0];
        end
`ifdef FETCHQ_BYPASS_EN
        else if (bypass) begin
            deq_valid      = 1'b1;
            deq_misaligned = enq_misaligned;
            deq_pc         = enq_pc;
            deq_instr      = enq_instr;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(wr_en) - CW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (nrst && wr_en)
            mem_q[wr_ptr_q] <= {enq_misaligned, enq_pc, enq_instr};
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default DEPTH=4, NOP_INSTR=32'h33).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic        enq_misaligned;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_misaligned;
    logic        deq_ready;
    logic        flush;
    logic [2:0]  count;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .NOP_INSTR(32'h0000_0033)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .enq_valid      (enq_valid),
        .enq_pc         (enq_pc),
        .enq_instr      (enq_instr),
        .enq_misaligned (enq_misaligned),
        .enq_ready      (enq_ready),
        .deq_valid      (deq_valid),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr),
        .deq_misaligned (deq_misaligned),
        .deq_ready      (deq_ready),
        .flush          (flush),
        .count          (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            checks_passed++;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic [31:0] pc);
        enq_valid      = 1'b1;
        enq_pc         = pc;
        enq_instr      = instr_of(pc);
        enq_misaligned = pc[2];
    endtask

    task automatic idle_enq();
        enq_valid      = 1'b0;
        enq_pc         = 32'h0;
        enq_instr      = 32'h0;
        enq_misaligned = 1'b0;
    endtask

    task automatic enq_one(input logic [31:0] pc);
        drive_enq(pc);
        deq_ready = 1'b0;
        tick();
        idle_enq();
        $display("enq pc=%h count=%0d", pc, count);
    endtask

    task automatic deq_expect(input string tag, input logic [31:0] pc);
        deq_ready = 1'b1;
        #1;
        check({tag, ".valid"}, {31'h0, deq_valid}, 32'h1);
        check({tag, ".pc"}, deq_pc, pc);
        check({tag, ".instr"}, deq_instr, instr_of(pc));
        check({tag, ".mis"}, {31'h0, deq_misaligned}, {31'h0, pc[2]});
        tick();
        deq_ready = 1'b0;
        $display("deq pc=%h", deq_pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".deq_valid"}, {31'h0, deq_valid}, 32'h0);
        check({tag, ".deq_instr"}, deq_instr, 32'h0000_0033);
        check({tag, ".deq_pc"}, deq_pc, 32'h0);
        check({tag, ".deq_mis"}, {31'h0, deq_misaligned}, 32'h0);
        check({tag, ".enq_ready"}, {31'h0, enq_ready}, 32'h1);
        check({tag, ".count"}, {29'h0, count}, 32'h0);
    endtask

    initial begin
        nrst = 1'b0;
        flush = 1'b0;
        deq_ready = 1'b0;
        idle_enq();
        tick();
        tick();
        nrst = 1'b1;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            check_reset_outputs("idle");
            tick();
        end

        // Fill to full, ignored fifth enqueue, drain in order
        for (int i = 0; i < 4; i++) enq_one(32'h4000_0000 + 32'(4 * i));
        check("fill.count", {29'h0, count}, 32'h4);
        check("fill.enq_ready", {31'h0, enq_ready}, 32'h0);
        enq_one(32'h4000_0010);
        check("fifth.count", {29'h0, count}, 32'h4);
        for (int i = 0; i < 4; i++) deq_expect("drain", 32'h4000_0000 + 32'(4 * i));
        check("drain.count", {29'h0, count}, 32'h0);
        check("drain.valid", {31'h0, deq_valid}, 32'h0);

        // Streaming: one in, one out per cycle
        deq_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive_enq(32'h4000_1000 + 32'(4 * k));
            #1;
`ifdef FETCHQ_BYPASS_EN
            check("stream.valid", {31'h0, deq_valid}, 32'h1);
            check("stream.pc", deq_pc, 32'h4000_1000 + 32'(4 * k));
`else
            if (k == 0) begin
                check("stream.valid0", {31'h0, deq_valid}, 32'h0);
            end else begin
                check("stream.valid", {31'h0, deq_valid}, 32'h1);
                check("stream.pc", deq_pc, 32'h4000_1000 + 32'(4 * (k - 1)));
            end
`endif
            check("stream.count_le1", {31'h0, (count <= 3'd1)}, 32'h1);
            $display("stream k=%0d enq=%h deq=%h count=%0d", k, enq_pc, deq_pc, count);
            tick();
        end
        idle_enq();
        deq_ready = 1'b0;
`ifndef FETCHQ_BYPASS_EN
        deq_expect("stream.last", 32'h4000_1000 + 32'(4 * 19));
`endif
        check("stream.count_end", {29'h0, count}, 32'h0);

        // Wrap-around
        for (int i = 0; i < 3; i++) enq_one(32'h4000_2000 + 32'(4 * i));
        for (int i = 0; i < 3; i++) deq_expect("wrap1", 32'h4000_2000 + 32'(4 * i));
        for (int i = 0; i < 4; i++) enq_one(32'h4000_3000 + 32'(4 * i));
        check("wrap.full", {29'h0, count}, 32'h4);
        for (int i = 0; i < 4; i++) deq_expect("wrap2", 32'h4000_3000 + 32'(4 * i));
        check("wrap.count", {29'h0, count}, 32'h0);

        // Flush with a same-cycle enqueue
        for (int i = 0; i < 3; i++) enq_one(32'h4000_0050 + 32'(4 * i));
        check("preflush.count", {29'h0, count}, 32'h3);
        flush = 1'b1;
        deq_ready = 1'b1;
        drive_enq(32'h4000_0100);
        tick();
        flush = 1'b0;
        deq_ready = 1'b0;
        idle_enq();
        $display("flush count=%0d", count);
        check("flush.count", {29'h0, count}, 32'h0);
        check("flush.valid", {31'h0, deq_valid}, 32'h0);
        enq_one(32'h4000_0200);
        check("postflush.count", {29'h0, count}, 32'h1);
        deq_expect("postflush", 32'h4000_0200);
        check("postflush.empty", {29'h0, count}, 32'h0);

        // Reset pulse while full with deq_ready high
        for (int i = 0; i < 4; i++) enq_one(32'h4000_0400 + 32'(4 * i));
        check("prereset.count", {29'h0, count}, 32'h4);
        deq_ready = 1'b1;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        deq_ready = 1'b0;
        $display("reset pulse count=%0d", count);
        check_reset_outputs("rstpulse");
        enq_one(32'h4000_0300);
        deq_expect("postreset", 32'h4000_0300);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
